// File: rtl/ifetch_pkg.sv
// Shared types for the instruction-fetch requester: FSM states, fetch-queue entry, PC step.
package ifetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALT
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } fq_entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO of fetch-queue entries with flush; head is always the oldest entry.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            push,
    input  logic            pop,
    input  fq_entry_t       din,
    output fq_entry_t       head,
    output logic [CW-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fq_entry_t       mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Flush wins over push/pop so a redirect leaves the queue empty.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_req.sv
// Instruction-fetch requester: PC, credit-limited SRAM requests, fetch queue toward decode.
// Optional misaligned-redirect trap enabled by defining IFETCH_ALIGN_CHK_EN.
module ifetch_req
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] ins_a,
    output logic        ins_e,
    input  logic [31:0] ins,
    input  logic        branch,
    input  logic [31:0] branch_tgt,
    input  logic        ifu_rdy,
    output logic        ifu_en,
    output logic [31:0] ifu_pc,
    output logic [31:0] ifu_ins,
    output logic        fetch_err
);

    localparam int CW = $clog2(FQ_DEPTH + 1);

    state_t          state;
    state_t          state_nx;
    logic [31:0]     pc;
    logic [31:0]     rpc;
    logic [31:0]     tgt;
    logic            inflight;
    logic            issue;
    logic            push;
    logic            pop;
    logic            credit_ok;
    logic            misaligned;
    logic            redirect;
    logic [CW-1:0]   count;
    fq_entry_t       head;

`ifdef IFETCH_ALIGN_CHK_EN
    assign tgt        = branch_tgt;
    assign misaligned = branch && (branch_tgt[1:0] != 2'b00);
`else
    assign tgt        = {branch_tgt[31:2], 2'b00};
    assign misaligned = 1'b0;
`endif

    assign redirect  = branch && (state != S_HALT);
    assign pop       = ifu_en && ifu_rdy;
    assign push      = inflight && !branch;
    assign credit_ok = (int'(count) + int'(inflight)) < FQ_DEPTH;

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        case (state)
            S_BOOT: state_nx = misaligned ? S_HALT : S_RUN;
            S_RUN: begin
                if (misaligned) begin
                    state_nx = S_HALT;
                end else begin
                    issue = !branch && (credit_ok || pop);
                end
            end
            S_HALT:  state_nx = S_HALT;
            default: state_nx = S_BOOT;
        endcase
    end

    // A redirect drops the outstanding response by clearing inflight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_BOOT;
            pc       <= RESET_PC;
            rpc      <= '0;
            inflight <= 1'b0;
        end else begin
            state <= state_nx;
            if (redirect) begin
                pc       <= tgt;
                inflight <= 1'b0;
            end else begin
                inflight <= issue;
                if (issue) begin
                    pc  <= pc + PC_STEP;
                    rpc <= pc;
                end
            end
        end
    end

`ifdef IFETCH_ALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_err <= 1'b0;
        end else if (misaligned && (state != S_HALT)) begin
            fetch_err <= 1'b1;
        end
    end
`else
    assign fetch_err = 1'b0;
`endif

    ifetch_fifo #(
        .DEPTH (FQ_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (branch),
        .push  (push),
        .pop   (pop),
        .din   ('{pc: rpc, ins: ins}),
        .head  (head),
        .count (count)
    );

    assign ins_a   = pc[15:0];
    assign ins_e   = issue;
    assign ifu_en  = (count != '0);
    assign ifu_pc  = ifu_en ? head.pc  : '0;
    assign ifu_ins = ifu_en ? head.ins : '0;

endmodule
